// File: rtl/y_window3x3.sv
// y_window3x3: builds a 3x3 luma neighbourhood per pixel from two line RAMs
// and a 3-column shift register; all outputs have a fixed 2-cycle latency.
module y_window3x3 #(
    parameter int DATA_W    = 8,
    parameter int MAX_WIDTH = 1920
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   y_i,
    input  logic                dv_i,
    input  logic                hs_i,
    input  logic                vs_i,
    output logic [9*DATA_W-1:0] win_o,
    output logic                dv_o,
    output logic                hs_o,
    output logic                vs_o,
    output logic                edge_o,
    output logic                ovf_o
);
    localparam int ADDR_W = $clog2(MAX_WIDTH + 1);
    localparam int RAM_AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
    localparam logic [ADDR_W-1:0] MAX_COL = ADDR_W'(MAX_WIDTH);

    // Streaming input with no backpressure: a pixel is taken on every cycle
    // dv_i is high, and each output cycle mirrors the input two cycles earlier.
    logic [ADDR_W-1:0] col_q, col_d;
    logic [1:0]        line_cnt_q, line_cnt_d;
    logic              dv_fall, vs_rise;

    logic [DATA_W-1:0] y_s1_q;
    logic              v_s1_q, hs_s1_q, vs_s1_q, ovp_s1_q, vsr_s1_q;
    logic [ADDR_W-1:0] col_s1_q;

    logic [DATA_W-1:0] lb0_mem [MAX_WIDTH];
    logic [DATA_W-1:0] lb1_mem [MAX_WIDTH];
    logic [DATA_W-1:0] lb0_q, lb1_q;
    logic [DATA_W-1:0] top, mid;

    logic [DATA_W-1:0] win_q [9];
    logic              dv_q, hs_q, vs_q, edge_q, ovf_q;

    logic [RAM_AW-1:0] rd_addr, wr_addr;
    logic              rd_en, wr_en;

    // v_s1_q / vs_s1_q double as the 1-cycle delayed dv_i / vs_i.
    assign dv_fall = v_s1_q & ~dv_i;
    assign vs_rise = vs_i & ~vs_s1_q;

    always_comb begin
        col_d = col_q;
        if (vs_rise || dv_fall) begin
            col_d = '0;
        end else if (dv_i && (col_q != MAX_COL)) begin
            col_d = col_q + ADDR_W'(1);
        end
    end

    always_comb begin
        line_cnt_d = line_cnt_q;
        if (vs_rise) begin
            line_cnt_d = 2'd0;
        end else if (dv_fall && (line_cnt_q != 2'd2)) begin
            line_cnt_d = line_cnt_q + 2'd1;
        end
    end

    assign rd_addr = col_q[RAM_AW-1:0];
    assign rd_en   = (col_q != MAX_COL);
    assign wr_addr = col_s1_q[RAM_AW-1:0];
    assign wr_en   = v_s1_q & ~ovp_s1_q;

    // Line RAMs are not reset; stale contents are hidden by line_cnt masking.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            lb0_q <= lb0_mem[rd_addr];
            lb1_q <= lb1_mem[rd_addr];
        end
        if (wr_en) begin
            lb0_mem[wr_addr] <= y_s1_q;
            lb1_mem[wr_addr] <= lb0_q;
        end
    end

    assign top = ((line_cnt_q < 2'd2) || ovp_s1_q) ? '0 : lb1_q;
    assign mid = ((line_cnt_q == 2'd0) || ovp_s1_q) ? '0 : lb0_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q      <= '0;
            line_cnt_q <= 2'd0;
            y_s1_q     <= '0;
            v_s1_q     <= 1'b0;
            hs_s1_q    <= 1'b0;
            vs_s1_q    <= 1'b0;
            ovp_s1_q   <= 1'b0;
            vsr_s1_q   <= 1'b0;
            col_s1_q   <= '0;
            dv_q       <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            edge_q     <= 1'b0;
            ovf_q      <= 1'b0;
            for (int p = 0; p < 9; p++) win_q[p] <= '0;
        end else begin
            col_q      <= col_d;
            line_cnt_q <= line_cnt_d;
            y_s1_q     <= y_i;
            v_s1_q     <= dv_i;
            hs_s1_q    <= hs_i;
            vs_s1_q    <= vs_i;
            ovp_s1_q   <= dv_i & (col_q == MAX_COL);
            vsr_s1_q   <= vs_rise;
            col_s1_q   <= col_q;
            dv_q       <= v_s1_q;
            hs_q       <= hs_s1_q;
            vs_q       <= vs_s1_q;
            edge_q     <= v_s1_q & ((line_cnt_q < 2'd2) | (col_s1_q < ADDR_W'(2)));
            // The frame-start clear is delayed one stage so it lines up with the pixel stream.
            if (vsr_s1_q) begin
                ovf_q <= 1'b0;
            end else if (ovp_s1_q) begin
                ovf_q <= 1'b1;
            end
            if (v_s1_q) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[3*r]   <= win_q[3*r+1];
                    win_q[3*r+1] <= win_q[3*r+2];
                end
                win_q[2] <= top;
                win_q[5] <= mid;
                win_q[8] <= y_s1_q;
            end else begin
                for (int p = 0; p < 9; p++) win_q[p] <= '0;
            end
        end
    end

    for (genvar p = 0; p < 9; p++) begin : g_win
        assign win_o[DATA_W*p +: DATA_W] = win_q[p];
    end

    assign dv_o   = dv_q;
    assign hs_o   = hs_q;
    assign vs_o   = vs_q;
    assign edge_o = edge_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_y_window3x3.sv
// Bench for y_window3x3: randomized frames against a line-based reference
// model; expected outputs are queued per input cycle and checked 2 cycles later.
module tb_y_window3x3;
  localparam int DW = 8;
  localparam int MW = 8;
  localparam int W  = 9*DW + 5;
  localparam int MAX_CYCLES = 20000;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     y_i;
  logic              dv_i, hs_i, vs_i;
  logic [9*DW-1:0]   win_o;
  logic              dv_o, hs_o, vs_o, edge_o, ovf_o;

  always #5 clk = ~clk;

  y_window3x3 #(.DATA_W(DW), .MAX_WIDTH(MW)) dut (
    .clk(clk), .rst(rst), .y_i(y_i), .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
    .win_o(win_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
    .edge_o(edge_o), .ovf_o(ovf_o)
  );

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int out_idx = 0;
  int cyc     = 0;

  // Reference model: whole lines of the current frame plus the window contents.
  logic [DW-1:0] cur_l   [MW];
  logic [DW-1:0] prev_l  [MW];
  logic [DW-1:0] prev2_l [MW];
  logic [DW-1:0] mw      [3][3];
  logic          m_dv_prev = 1'b0;
  logic          m_vs_prev = 1'b0;
  int            m_col     = 0;
  int            m_lines   = 0;
  logic          m_ovf     = 1'b0;

  always @(posedge clk) cyc++;

  task automatic model_reset();
    m_dv_prev = 1'b0;
    m_vs_prev = 1'b0;
    m_col     = 0;
    m_lines   = 0;
    m_ovf     = 1'b0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) mw[r][c] = '0;
  endtask

  task automatic check_idle(input string tag);
    logic [W-1:0] act;
    act = {dv_o, hs_o, vs_o, edge_o, ovf_o, win_o};
    n_tests++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL reset-state %s act=%h exp=0", tag, act);
    end
  endtask

  task automatic step(input logic r, input logic dv, input logic [DW-1:0] y,
                      input logic hs, input logic vs);
    logic [W-1:0]  e;
    logic [DW-1:0] top, mid;
    logic          vs_rise, dv_fall, edg;
    int            c;
    rst = r; dv_i = dv; y_i = y; hs_i = hs; vs_i = vs;
    e = '0;
    if (r) begin
      // A reset also kills the pixel issued in the previous cycle.
      if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
      model_reset();
    end else begin
      vs_rise = vs & ~m_vs_prev;
      dv_fall = ~dv & m_dv_prev;
      if (dv_fall) begin
        prev2_l = prev_l;
        prev_l  = cur_l;
        m_col   = 0;
        if (m_lines < 2) m_lines++;
      end
      if (vs_rise) begin
        m_lines = 0;
        m_ovf   = 1'b0;
        m_col   = 0;
      end
      edg = 1'b0;
      if (dv) begin
        c   = m_col;
        top = (m_lines >= 2 && c < MW) ? prev2_l[c] : '0;
        mid = (m_lines >= 1 && c < MW) ? prev_l[c]  : '0;
        if (c < MW) cur_l[c] = y;
        else if (!vs_rise) m_ovf = 1'b1;
        for (int rr = 0; rr < 3; rr++) begin
          mw[rr][0] = mw[rr][1];
          mw[rr][1] = mw[rr][2];
        end
        mw[0][2] = top;
        mw[1][2] = mid;
        mw[2][2] = y;
        edg   = (m_lines < 2) || (c < 2);
        m_col = (c < MW) ? c + 1 : MW;
      end else begin
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++) mw[rr][cc] = '0;
      end
      for (int rr = 0; rr < 3; rr++)
        for (int cc = 0; cc < 3; cc++) e[DW*(3*rr+cc) +: DW] = mw[rr][cc];
      e[W-1] = dv;
      e[W-2] = hs;
      e[W-3] = vs;
      e[W-4] = edg;
      e[W-5] = m_ovf;
      m_dv_prev = dv;
      m_vs_prev = vs;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: output cycle n reflects the entry pushed for input cycle n-2.
  always @(negedge clk) begin
    logic [W-1:0] e, act;
    if (exp_q.size() >= 3) begin
      e   = exp_q.pop_front();
      act = {dv_o, hs_o, vs_o, edge_o, ovf_o, win_o};
      n_tests++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL out_cyc%0d act=%h exp=%h (dv,hs,vs,edge,ovf,win)",
                 out_idx, act, e);
      end
      out_idx++;
    end
  end

  // Watchdog: the run must finish within a fixed cycle budget.
  initial begin
    wait (cyc >= MAX_CYCLES);
    n_fail++;
    $display("FAIL timeout after %0d cycles", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic blank(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, DW'($urandom), ($urandom_range(0, 3) == 0), 1'b0);
  endtask

  task automatic vs_pulse(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, DW'($urandom), 1'b0, 1'b1);
  endtask

  // kind 0: ramp 16*row+col, 1: random, 2: constant 0xAA
  task automatic line(input int n, input int kind, input int row);
    logic [DW-1:0] y;
    for (int c = 0; c < n; c++) begin
      case (kind)
        0:       y = DW'(16*row + c);
        2:       y = 8'hAA;
        default: y = DW'($urandom);
      endcase
      step(1'b0, 1'b1, y, ($urandom_range(0, 7) == 0), 1'b0);
    end
  endtask

  task automatic frame(input int lines, input int width, input int kind, input int gap);
    vs_pulse(1);
    blank(gap);
    for (int r = 0; r < lines; r++) begin
      line(width, kind, r);
      blank(gap);
    end
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (exp_q.size() >= 3 && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    n_tests++;
    if (exp_q.size() >= 3) begin
      n_fail++;
      $display("FAIL drain wait expired with %0d entries pending", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1; dv_i = 1'b0; y_i = '0; hs_i = 1'b0; vs_i = 1'b0;
    for (int i = 0; i < MW; i++) begin
      cur_l[i] = '0; prev_l[i] = '0; prev2_l[i] = '0;
    end
    model_reset();
    @(posedge clk);
    #1;

    // reset held with dv_i high
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, DW'($urandom), 1'b0, 1'b0);
      check_idle($sformatf("hold%0d", i));
    end
    blank(1);
    check_idle("release");
    blank(1);

    // ramp frame
    frame(4, 4, 0, 2);

    // overflow: 10-pixel line, then lines reading back the first 8 columns
    vs_pulse(1);
    blank(2);
    line(10, 1, 0); blank(2);
    line(8, 1, 1);  blank(2);
    line(8, 1, 2);  blank(3);
    frame(1, 4, 1, 2);

    // frame restart after 3 lines, then a constant frame
    frame(3, 6, 1, 2);
    frame(3, 6, 2, 2);

    // reset in the middle of line 2, then a clean frame
    vs_pulse(2);
    blank(2);
    line(5, 1, 0); blank(2);
    line(5, 1, 1); blank(2);
    line(2, 1, 2);
    step(1'b1, 1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b0, DW'($urandom), 1'b0, 1'b0);
    blank(2);
    frame(4, 5, 1, 2);

    // random frames, including some lines wider than MW
    for (int f = 0; f < 6; f++)
      frame($urandom_range(1, 5), $urandom_range(1, 10), 1, $urandom_range(1, 4));

    blank(4);
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    if (n_fail == 0) $display("[TB] PASS");
    else             $display("[TB] FAIL");
    $finish;
  end

endmodule
